pc_gen_unit: RTL and testbench



---
 rtl/pc_gen_unit_if.sv | 24 ++
 rtl/pc_gen_unit.sv | 66 ++++++
 tb/tb_pc_gen_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_gen_unit_if.sv
// pc_gen_unit_if: fetch-PC control and status bundle between the core and the PC generator.
interface pc_gen_unit_if #(parameter int XLEN = 32);
    logic            en;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic            dbg_halt_req;
    logic            dbg_resume_req;
    logic [XLEN-1:0] current_pc_if1;
    logic            pc_valid;
    logic            halted;
    logic [XLEN-1:0] dpc;
    logic            misalign_fault;
    logic [XLEN-1:0] misalign_addr;
    modport master (
        output en, br_valid, br_target, trap_valid, trap_target, dbg_halt_req, dbg_resume_req,
        input  current_pc_if1, pc_valid, halted, dpc, misalign_fault, misalign_addr
    );
    modport slave (
        input  en, br_valid, br_target, trap_valid, trap_target, dbg_halt_req, dbg_resume_req,
        output current_pc_if1, pc_valid, halted, dpc, misalign_fault, misalign_addr
    );
endinterface

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: IF1 fetch PC with sequential/branch/trap redirect, debug halt/resume and target alignment check.
module pc_gen_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'hFFFFF000,
    parameter int              IALIGN       = 4
) (
    input logic           clk,
    input logic           reset,
    pc_gen_unit_if.slave  bus
);
    localparam int AW = $clog2(IALIGN);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t          state;
    logic [XLEN-1:0] pc, dpc, misalign_addr, seq_pc, cand_pc;
    logic            pc_valid, halted, misalign_fault, aligned;
    always_comb begin
        aligned = bus.br_target[AW-1:0] == '0;
        seq_pc  = pc + XLEN'(IALIGN);
        cand_pc = (bus.br_valid && aligned) ? bus.br_target : seq_pc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= RESET_VECTOR;
            pc_valid       <= 1'b0;
            halted         <= 1'b0;
            dpc            <= '0;
            misalign_fault <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_fault <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (bus.trap_valid) pc <= bus.trap_target;
                    else if (bus.dbg_halt_req) begin
                        dpc      <= cand_pc;
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (bus.br_valid && aligned) pc <= bus.br_target;
                    else if (bus.br_valid) begin
                        misalign_fault <= 1'b1;
                        misalign_addr  <= bus.br_target;
                    end else if (bus.en) pc <= seq_pc;
                end
                HALT: if (bus.dbg_resume_req) begin
                    pc       <= dpc;
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    halted   <= 1'b0;
                end
                default: state <= BOOT;
            endcase
        end
    end
    assign bus.current_pc_if1 = pc;
    assign bus.pc_valid       = pc_valid;
    assign bus.halted         = halted;
    assign bus.dpc            = dpc;
    assign bus.misalign_fault = misalign_fault;
    assign bus.misalign_addr  = misalign_addr;
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed scoreboard bench for the fetch PC generator.
module tb_pc_gen_unit;
    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        mf;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    pc_gen_unit_if #(.XLEN(32)) bus ();
    pc_gen_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step(input string tag, input logic [31:0] pc, input logic v, input logic h, input logic mf);
        exp_t e;
        sb.push_back('{tag, pc, v, h, mf});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".pc"}, bus.current_pc_if1, e.pc);
            cmp({e.tag, ".valid"}, 32'(bus.pc_valid), 32'(e.v));
            cmp({e.tag, ".halted"}, 32'(bus.halted), 32'(e.h));
            cmp({e.tag, ".mf"}, 32'(bus.misalign_fault), 32'(e.mf));
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.en = 1'b1;
        bus.br_valid = 1'b0;
        bus.br_target = '0;
        bus.trap_valid = 1'b0;
        bus.trap_target = '0;
        bus.dbg_halt_req = 1'b0;
        bus.dbg_resume_req = 1'b0;
        step("rst", 32'hFFFFF000, 0, 0, 0);
        cmp("rst.dpc", bus.dpc, 32'h0);
        cmp("rst.maddr", bus.misalign_addr, 32'h0);
        reset = 1'b0;
        step("boot", 32'hFFFFF000, 1, 0, 0);
        step("seq1", 32'hFFFFF004, 1, 0, 0);
        step("seq2", 32'hFFFFF008, 1, 0, 0);
        bus.en = 1'b0;
        bus.br_valid = 1'b1;
        bus.br_target = 32'h80000010;
        step("br_jump", 32'h80000010, 1, 0, 0);
        bus.br_target = 32'h80000100;
        step("br_stall", 32'h80000100, 1, 0, 0);
        bus.br_target = 32'h80000102;
        step("mis_pulse", 32'h80000100, 1, 0, 1);
        cmp("mis_addr", bus.misalign_addr, 32'h80000102);
        bus.br_valid = 1'b0;
        step("mis_once", 32'h80000100, 1, 0, 0);
        bus.trap_valid = 1'b1;
        bus.trap_target = 32'h00000200;
        step("trap", 32'h00000200, 1, 0, 0);
        bus.trap_valid = 1'b0;
        bus.en = 1'b1;
        step("seq3", 32'h00000204, 1, 0, 0);
        bus.trap_valid = 1'b1;
        bus.br_valid = 1'b1;
        bus.br_target = 32'h00000300;
        step("trap_over_br", 32'h00000200, 1, 0, 0);
        bus.trap_valid = 1'b0;
        bus.br_target = 32'h80000040;
        step("br_40", 32'h80000040, 1, 0, 0);
        bus.br_valid = 1'b0;
        bus.dbg_halt_req = 1'b1;
        step("halt", 32'h80000040, 0, 1, 0);
        cmp("halt.dpc", bus.dpc, 32'h80000044);
        bus.br_valid = 1'b1;
        bus.br_target = 32'h00000100;
        bus.trap_valid = 1'b1;
        bus.trap_target = 32'h00000500;
        step("halt_ignore", 32'h80000040, 0, 1, 0);
        bus.br_valid = 1'b0;
        bus.trap_valid = 1'b0;
        bus.dbg_resume_req = 1'b1;
        step("resume", 32'h80000044, 1, 0, 0);
        bus.dbg_resume_req = 1'b0;
        bus.dbg_halt_req = 1'b0;
        bus.en = 1'b0;
        step("run_hold", 32'h80000044, 1, 0, 0);
        bus.br_valid = 1'b1;
        bus.br_target = 32'h80000080;
        bus.dbg_halt_req = 1'b1;
        step("halt_br", 32'h80000044, 0, 1, 0);
        cmp("halt_br.dpc", bus.dpc, 32'h80000080);
        bus.br_valid = 1'b0;
        bus.dbg_resume_req = 1'b1;
        bus.dbg_halt_req = 1'b0;
        step("resume_br", 32'h80000080, 1, 0, 0);
        bus.dbg_resume_req = 1'b0;
        bus.br_valid = 1'b1;
        bus.br_target = 32'hFFFFFFFC;
        step("br_top", 32'hFFFFFFFC, 1, 0, 0);
        bus.br_valid = 1'b0;
        bus.en = 1'b1;
        step("wrap", 32'h00000000, 1, 0, 0);
        step("post_wrap", 32'h00000004, 1, 0, 0);
        bus.trap_valid = 1'b1;
        bus.trap_target = 32'h00000300;
        bus.dbg_halt_req = 1'b1;
        step("trap_over_halt", 32'h00000300, 1, 0, 0);
        bus.trap_valid = 1'b0;
        step("halt_late", 32'h00000300, 0, 1, 0);
        cmp("halt_late.dpc", bus.dpc, 32'h00000304);
        reset = 1'b1;
        step("rst_halt", 32'hFFFFF000, 0, 0, 0);
        cmp("rst_halt.dpc", bus.dpc, 32'h0);
        reset = 1'b0;
        bus.dbg_halt_req = 1'b0;
        step("reboot", 32'hFFFFF000, 1, 0, 0);
        step("reboot_seq", 32'hFFFFF004, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
